// File: rtl/volt_tackle_control.sv
// Sequencer for the volt_tackle attack datapath. Draws Pikachu, waits one
// animation frame, steps Pikachu, and repeats until the datapath reports the
// shift point. It then draws the hurt Meowth and holds until the attack ends.
// Every output is a register decoded from the next state.
module volt_tackle_control #(
  parameter int MOVE_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset_all,
  input  logic       start,
  input  logic       done_animate_vt,
  input  logic       done_pikachu_vt,
  input  logic       done_shift,
  input  logic       done_vt,
  input  logic       done_hurt_meowth,
  output logic       dp_reset_n,
  output logic       enable_animate,
  output logic       enable_p_vt,
  output logic       enable_draw_pika_vt,
  output logic       enable_draw_hurt_meowth,
  output logic       choose,
  output logic       plot,
  output logic       busy,
  output logic       attack_done,
  output logic       timeout_err,
  output logic [5:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW_PIKA, S_WAIT, S_MOVE, S_DRAW_MEOWTH, S_HOLD, S_DONE
  } state_t;

  // Last cycle index before a wait state gives up, and last index of a step.
  localparam logic [19:0] WAIT_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  MOVE_LAST = 4'(MOVE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [19:0] wait_q, wait_d;
  logic [3:0]  move_q, move_d;
  logic        shift_q, shift_d;
  logic [5:0]  fc_d;
  logic        terr_d;
  logic        timed_out, entering, counted;

  // Next-state logic. A done input always beats a timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    fc_d      = frame_count;
    terr_d    = timeout_err;
    timed_out = (wait_q == WAIT_LAST);
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_DRAW_PIKA;
        fc_d    = '0;
        shift_d = 1'b0;
        terr_d  = 1'b0;
      end
      S_DRAW_PIKA: begin
        if (done_pikachu_vt) state_d = S_WAIT;
        else if (timed_out) begin state_d = S_DONE; terr_d = 1'b1; end
      end
      S_WAIT: begin
        // A shift arriving with the frame tick still counts for this decision.
        shift_d = shift_q | done_shift;
        if (done_animate_vt) begin
          if (frame_count != 6'd63) fc_d = frame_count + 6'd1;
          state_d = shift_d ? S_DRAW_MEOWTH : S_MOVE;
        end else if (timed_out) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
        end
      end
      S_MOVE: if (move_q == MOVE_LAST) state_d = S_DRAW_PIKA;
      S_DRAW_MEOWTH: begin
        if (done_hurt_meowth) state_d = S_HOLD;
        else if (timed_out) begin state_d = S_DONE; terr_d = 1'b1; end
      end
      S_HOLD: begin
        if (done_vt) state_d = S_DONE;
        else if (timed_out) begin state_d = S_DONE; terr_d = 1'b1; end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    entering = (state_d != state_q);
    counted  = (state_q == S_DRAW_PIKA) || (state_q == S_WAIT) ||
               (state_q == S_DRAW_MEOWTH) || (state_q == S_HOLD);
    if (entering)     wait_d = '0;
    else if (counted) wait_d = wait_q + 20'd1;
    else              wait_d = wait_q;
    move_d = entering ? '0 : move_q + 4'd1;
  end

  // State, counters and Moore outputs. choose is only allowed to flip on entry
  // into the Meowth draw, so plot waits one cycle there until the mux settles.
  always_ff @(posedge clock) begin
    if (reset_all) begin
      state_q                 <= S_IDLE;
      wait_q                  <= '0;
      move_q                  <= '0;
      shift_q                 <= 1'b0;
      dp_reset_n              <= 1'b0;
      enable_animate          <= 1'b0;
      enable_p_vt             <= 1'b0;
      enable_draw_pika_vt     <= 1'b0;
      enable_draw_hurt_meowth <= 1'b0;
      choose                  <= 1'b0;
      plot                    <= 1'b0;
      busy                    <= 1'b0;
      attack_done             <= 1'b0;
      timeout_err             <= 1'b0;
      frame_count             <= '0;
    end else begin
      state_q                 <= state_d;
      wait_q                  <= wait_d;
      move_q                  <= move_d;
      shift_q                 <= shift_d;
      frame_count             <= fc_d;
      timeout_err             <= terr_d;
      dp_reset_n              <= (state_d != S_IDLE) && (state_d != S_DONE);
      enable_animate          <= (state_d == S_WAIT) || (state_d == S_HOLD);
      enable_p_vt             <= (state_d == S_MOVE);
      enable_draw_pika_vt     <= (state_d == S_DRAW_PIKA);
      enable_draw_hurt_meowth <= (state_d == S_DRAW_MEOWTH);
      choose                  <= (state_d == S_DRAW_MEOWTH) || (state_d == S_HOLD);
      plot                    <= (state_d == S_DRAW_PIKA) ||
                                 ((state_d == S_DRAW_MEOWTH) && (state_q == S_DRAW_MEOWTH));
      busy                    <= (state_d != S_IDLE);
      attack_done             <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_volt_tackle_control.sv
// Bench for volt_tackle_control: directed walk through an attack, a reset
// mid-step, a timeout and spurious inputs, then random traffic against a
// cycle-level reference model of the attack sequence.
module tb_volt_tackle_control;
  localparam int MC = 3;
  localparam int TO = 100;

  localparam int P_IDLE = 0, P_PIKA = 1, P_WAIT = 2, P_MOVE = 3,
                 P_MEOW = 4, P_HOLD = 5, P_DONE = 6;

  logic clock = 1'b0;
  logic reset_all, start, done_animate_vt, done_pikachu_vt, done_shift, done_vt, done_hurt_meowth;
  logic dp_reset_n, enable_animate, enable_p_vt, enable_draw_pika_vt, enable_draw_hurt_meowth;
  logic choose, plot, busy, attack_done, timeout_err;
  logic [5:0] frame_count;
  logic b_dp, b_anim, b_pvt, b_dpk, b_dmw, b_ch, b_plot, b_busy, b_ad, b_te;
  logic [5:0] b_fc;

  int errors = 0;
  int checks = 0;

  // model state
  int m_ph = P_IDLE, m_t = 0, m_fc = 0;
  bit m_sh = 0, m_te = 0, m_ent = 0;
  logic prev_choose = 1'b0;

  always #5 clock = ~clock;

  volt_tackle_control #(.MOVE_CYCLES(MC), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_all(reset_all), .start(start),
    .done_animate_vt(done_animate_vt), .done_pikachu_vt(done_pikachu_vt),
    .done_shift(done_shift), .done_vt(done_vt), .done_hurt_meowth(done_hurt_meowth),
    .dp_reset_n(dp_reset_n), .enable_animate(enable_animate), .enable_p_vt(enable_p_vt),
    .enable_draw_pika_vt(enable_draw_pika_vt), .enable_draw_hurt_meowth(enable_draw_hurt_meowth),
    .choose(choose), .plot(plot), .busy(busy), .attack_done(attack_done),
    .timeout_err(timeout_err), .frame_count(frame_count));

  // second instance, single-cycle step, only used to measure its step width
  volt_tackle_control #(.MOVE_CYCLES(1), .TIMEOUT_CYCLES(TO)) dut1 (
    .clock(clock), .reset_all(reset_all), .start(start),
    .done_animate_vt(done_animate_vt), .done_pikachu_vt(done_pikachu_vt),
    .done_shift(done_shift), .done_vt(done_vt), .done_hurt_meowth(done_hurt_meowth),
    .dp_reset_n(b_dp), .enable_animate(b_anim), .enable_p_vt(b_pvt),
    .enable_draw_pika_vt(b_dpk), .enable_draw_hurt_meowth(b_dmw),
    .choose(b_ch), .plot(b_plot), .busy(b_busy), .attack_done(b_ad),
    .timeout_err(b_te), .frame_count(b_fc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: advance the attack sequence by one clock given this cycle's inputs.
  task automatic model(input bit rs, st, dp, da, ds, dv, dh);
    int nph;
    bit tout;
    if (rs) begin
      m_ph = P_IDLE; m_t = 0; m_fc = 0; m_sh = 0; m_te = 0; m_ent = 1;
      return;
    end
    nph  = m_ph;
    tout = (m_t + 1 >= TO);
    case (m_ph)
      P_IDLE: if (st) begin nph = P_PIKA; m_fc = 0; m_sh = 0; m_te = 0; end
      P_PIKA: if (dp) nph = P_WAIT; else if (tout) begin nph = P_DONE; m_te = 1; end
      P_WAIT: begin
        if (ds) m_sh = 1;
        if (da) begin
          m_fc = (m_fc < 63) ? m_fc + 1 : 63;
          nph  = m_sh ? P_MEOW : P_MOVE;
        end else if (tout) begin nph = P_DONE; m_te = 1; end
      end
      P_MOVE: if (m_t + 1 >= MC) nph = P_PIKA;
      P_MEOW: if (dh) nph = P_HOLD; else if (tout) begin nph = P_DONE; m_te = 1; end
      P_HOLD: if (dv) nph = P_DONE; else if (tout) begin nph = P_DONE; m_te = 1; end
      default: nph = P_IDLE;
    endcase
    m_ent = (nph != m_ph);
    m_t   = m_ent ? 0 : m_t + 1;
    m_ph  = nph;
  endtask

  function automatic logic [15:0] expect_vec();
    logic [15:0] v;
    v[15] = (m_ph != P_IDLE) && (m_ph != P_DONE);
    v[14] = (m_ph == P_WAIT) || (m_ph == P_HOLD);
    v[13] = (m_ph == P_MOVE);
    v[12] = (m_ph == P_PIKA);
    v[11] = (m_ph == P_MEOW);
    v[10] = (m_ph == P_MEOW) || (m_ph == P_HOLD);
    v[9]  = (m_ph == P_PIKA) || ((m_ph == P_MEOW) && !m_ent);
    v[8]  = (m_ph != P_IDLE);
    v[7]  = (m_ph == P_DONE);
    v[6]  = m_te;
    v[5:0] = 6'(m_fc);
    return v;
  endfunction

  // One clock: drive inputs, advance model, sample #1 after the edge, compare.
  task automatic step(input bit rs, st, dp, da, ds, dv, dh);
    reset_all = rs; start = st; done_pikachu_vt = dp; done_animate_vt = da;
    done_shift = ds; done_vt = dv; done_hurt_meowth = dh;
    model(rs, st, dp, da, ds, dv, dh);
    prev_choose = choose;
    @(posedge clock);
    #1;
    chk("outputs", {dp_reset_n, enable_animate, enable_p_vt, enable_draw_pika_vt,
                    enable_draw_hurt_meowth, choose, plot, busy, attack_done,
                    timeout_err, frame_count}, expect_vec());
    if (plot) chk("plot_choose_stable", choose, prev_choose);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n3, n1, n;
    bit st, dp, da, ds, dv, dh, rs, stall;

    // reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_dp_reset_n", dp_reset_n, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_count", frame_count, 0);

    // start -> Pikachu draw
    step(0, 1, 0, 0, 0, 0, 0);
    chk("start_busy", busy, 1);
    chk("start_dp_reset_n", dp_reset_n, 1);
    chk("start_draw_pika", enable_draw_pika_vt, 1);
    chk("start_plot", plot, 1);
    chk("start_choose", choose, 0);
    repeat (8) idle();
    step(0, 0, 1, 0, 0, 0, 0);
    chk("wait_enable_animate", enable_animate, 1);
    chk("wait_plot", plot, 0);
    idle();
    idle();

    // first frame tick, step widths for MOVE_CYCLES=3 and 1
    n3 = 0; n1 = 0;
    step(0, 0, 0, 1, 0, 0, 0);
    chk("tick1_frame_count", frame_count, 1);
    if (enable_p_vt) n3++;
    if (b_pvt) n1++;
    for (int i = 0; i < 7; i++) begin
      idle();
      if (enable_p_vt) n3++;
      if (b_pvt) n1++;
    end
    chk("move_width_3", n3, MC);
    chk("move_width_1", n1, 1);
    chk("redraw_pika", enable_draw_pika_vt, 1);

    // frames 2..50 without shift, then shift seen with tick 51
    for (int f = 2; f <= 50; f++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      repeat (MC) idle();
    end
    chk("frames_50", frame_count, 50);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    chk("meowth_choose", choose, 1);
    chk("meowth_draw", enable_draw_hurt_meowth, 1);
    chk("meowth_frame_count", frame_count, 51);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("meowth_plot", plot, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("hold_choose", choose, 1);
    chk("hold_plot", plot, 0);
    idle();
    step(0, 0, 0, 0, 0, 1, 0);
    chk("done_pulse", attack_done, 1);
    idle();
    chk("done_pulse_end", attack_done, 0);
    chk("done_idle_busy", busy, 0);

    // reset in the middle of a step
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("pre_reset_move", enable_p_vt, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("midreset_pvt", enable_p_vt, 0);
    chk("midreset_dp_reset_n", dp_reset_n, 0);
    chk("midreset_busy", busy, 0);
    repeat (3) idle();
    chk("midreset_frame_count", frame_count, 0);

    // timeout while waiting for the Pikachu drawer
    n = 0;
    step(0, 1, 0, 0, 0, 0, 0);
    while (enable_draw_pika_vt && n < 3 * TO) begin
      n++;
      idle();
    end
    chk("timeout_len", n, TO);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_done", attack_done, 1);
    idle();
    chk("timeout_sticky", timeout_err, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("timeout_cleared", timeout_err, 0);

    // spurious start / done_hurt_meowth in the frame wait
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("spurious_animate", enable_animate, 1);
    chk("spurious_done", attack_done, 0);
    chk("spurious_meowth", enable_draw_hurt_meowth, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // random traffic with periodic stalls to exercise timeouts
    for (int c = 0; c < 4000; c++) begin
      stall = ((c % 1000) >= 700) && ((c % 1000) < 950);
      rs = ($urandom_range(299) == 0);
      st = ($urandom_range(3) == 0);
      dp = !stall && ($urandom_range(5) == 0);
      da = !stall && ($urandom_range(4) == 0);
      ds = !stall && ($urandom_range(7) == 0);
      dv = !stall && ($urandom_range(7) == 0);
      dh = !stall && ($urandom_range(5) == 0);
      step(rs, st, dp, da, ds, dv, dh);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
